// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its detector bench.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_W = 4;
    localparam int DEFAULT_R = 4;

    localparam logic [3:0] DETECT_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable W-bit left-shift register; a load MSB-aligns bit len-1 so the serial bit is always the MSB.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic                 i_clear,
    input  logic [W-1:0]         i_data,
    input  logic [$clog2(W):0]   i_len,
    output logic                 o_msb
);

    localparam int LW = $clog2(W) + 1;

    logic [W-1:0]  r_data;
    logic [LW-1:0] w_align;

    assign w_align = LW'(W) - i_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data << w_align;
        end else if (i_shift) begin
            r_data <= r_data << 1;
        end
    end

    assign o_msb = r_data[W-1];

endmodule

// File: rtl/seq_generator.sv
// Serialises a captured pattern MSB-first, reps times back to back, then pulses done.
// Optional macro SEQ_GENERATOR_LOOP_EN adds a loop input that restarts the repetitions.
module seq_generator
    import seq_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int R = DEFAULT_R
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef SEQ_GENERATOR_LOOP_EN
    input  logic               loop,
`endif
    input  logic [W-1:0]       pattern,
    input  logic [$clog2(W):0] len,
    input  logic [R-1:0]       reps,
    output logic               x,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam int LW = $clog2(W) + 1;
    localparam logic [LW-1:0] W_LEN = LW'(W);

    state_t        r_state;
    state_t        w_nextState;
    logic [W-1:0]  r_pattern;
    logic [LW-1:0] r_len;
    logic [R-1:0]  r_repsM1;
    logic [LW-1:0] r_bitCnt;
    logic [R-1:0]  r_repCnt;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic [LW-1:0] w_lenClamp;
    logic [R-1:0]  w_repsM1;
    logic          w_capture;
    logic          w_loop;
    logic          w_load;
    logic          w_shift;
    logic          w_clear;
    logic [W-1:0]  w_loadData;
    logic [LW-1:0] w_loadLen;
    logic [LW-1:0] w_bitCntNext;
    logic [R-1:0]  w_repCntNext;
    logic          w_msb;

`ifdef SEQ_GENERATOR_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    // A zero repeat count still sends the pattern once, so store reps-1 saturated at zero
    assign w_lenClamp = (len > W_LEN) ? W_LEN : len;
    assign w_repsM1   = (reps == '0) ? '0 : reps - R'(1);
    assign w_capture  = (r_state == IDLE) && start && !abort;

    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_loadData   = r_pattern;
        w_loadLen    = r_len;
        w_bitCntNext = r_bitCnt;
        w_repCntNext = r_repCnt;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    if (w_lenClamp == '0) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState  = SHIFT;
                        w_load       = 1'b1;
                        w_loadData   = pattern;
                        w_loadLen    = w_lenClamp;
                        w_bitCntNext = w_lenClamp - LW'(1);
                        w_repCntNext = w_repsM1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_nextState = IDLE;
                    w_clear     = 1'b1;
                end else if (r_bitCnt == '0) begin
                    // Reloading on the last bit keeps valid high across repetitions
                    if (r_repCnt != '0) begin
                        w_load       = 1'b1;
                        w_bitCntNext = r_len - LW'(1);
                        w_repCntNext = r_repCnt - R'(1);
                    end else if (w_loop) begin
                        w_load       = 1'b1;
                        w_bitCntNext = r_len - LW'(1);
                        w_repCntNext = r_repsM1;
                    end else begin
                        w_nextState = DONE;
                        w_clear     = 1'b1;
                    end
                end else begin
                    w_shift      = 1'b1;
                    w_bitCntNext = r_bitCnt - LW'(1);
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_repsM1  <= '0;
            r_bitCnt  <= '0;
            r_repCnt  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_bitCnt <= w_bitCntNext;
            r_repCnt <= w_repCntNext;
            r_valid  <= (w_nextState == SHIFT);
            r_busy   <= (w_nextState != IDLE);
            r_done   <= (w_nextState == DONE);
            if (w_capture) begin
                r_pattern <= pattern;
                r_len     <= w_lenClamp;
                r_repsM1  <= w_repsM1;
            end
        end
    end

    seq_shift_reg #(
        .W(W)
    ) u_shiftReg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_data  (w_loadData),
        .i_len   (w_loadLen),
        .o_msb   (w_msb)
    );

    assign x     = w_msb;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: directed scenarios plus randomized traffic against a bit-queue model.
module tb_seq_generator;
    import seq_pkg::*;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int LW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [LW-1:0] len = '0;
    logic [R-1:0]  reps = '0;
    logic          x;
    logic          valid;
    logic          busy;
    logic          done;

    int nVectors = 0;
    int nMiscompares = 0;
    bit cmpEn = 1'b0;

    // Reference model: 0 idle, 1 sending, 2 done; queue holds the bits still to appear on x
    int            mState = 0;
    bit            mQ[$];
    logic [W-1:0]  mPat = '0;
    int            mLen = 0;
    int            mReps = 0;

    seq_generator #(
        .W(W),
        .R(R)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
`ifdef SEQ_GENERATOR_LOOP_EN
        .loop    (loop),
`endif
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void fillQueue();
        for (int r = 0; r < mReps; r++) begin
            for (int i = mLen - 1; i >= 0; i--) begin
                mQ.push_back(mPat[i]);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mState = 0;
            mQ.delete();
        end else begin
            case (mState)
                0: begin
                    if (start && !abort) begin
                        mPat  = pattern;
                        mLen  = (int'(len) > W) ? W : int'(len);
                        mReps = (reps == '0) ? 1 : int'(reps);
                        if (mLen == 0) begin
                            mState = 2;
                        end else begin
                            fillQueue();
                            mState = 1;
                        end
                    end
                end
                1: begin
                    if (abort) begin
                        mQ.delete();
                        mState = 0;
                    end else begin
                        void'(mQ.pop_front());
                        if (mQ.size() == 0) begin
                            if (loop) fillQueue();
                            else mState = 2;
                        end
                    end
                end
                default: mState = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            logic [3:0] expOut;
            logic       expValid;
            expValid = (mState == 1);
            expOut = {expValid ? logic'(mQ[0]) : 1'b0, expValid, mState != 0, mState == 2};
            nVectors++;
            if ({x, valid, busy, done} !== expOut) begin
                nMiscompares++;
                $display("[TB] FAIL cycle-check t=%0t x/valid/busy/done got %b required %b",
                         $time, {x, valid, busy, done}, expOut);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] pat, input logic [LW-1:0] l, input logic [R-1:0] r);
        pattern = pat;
        len     = l;
        reps    = r;
        start   = 1'b1;
    endtask

    // Samples each cycle after the start edge; returns the valid bits, counts and first done cycle
    task automatic runCapture(input int cycles, input bit keepStart, input logic [W-1:0] patAfter,
                              output logic [31:0] bits, output int nValid, output int nDone,
                              output int doneCyc);
        bits = '0;
        nValid = 0;
        nDone = 0;
        doneCyc = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (valid) begin
                bits = {bits[30:0], x};
                nValid++;
            end
            if (done) begin
                nDone++;
                if (doneCyc == 0) doneCyc = c;
            end
            if (!keepStart) start = 1'b0;
            pattern = patAfter;
        end
    endtask

    initial begin
        logic [31:0] bits;
        int nValid;
        int nDone;
        int doneCyc;

        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {28'd0, x, valid, busy, done}, 32'd0);
        rst = 1'b0;
        cmpEn = 1'b1;

        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(6, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        checkOutput("single bits", bits, 32'b0110);
        checkOutput("single valid count", nValid, 4);
        checkOutput("single done cycle", doneCyc, 5);
        checkOutput("single busy after", busy, 0);

        applyStimulus(DETECT_PATTERN, 3'd4, 4'd3);
        runCapture(14, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        checkOutput("reps3 bits", bits, 32'b011001100110);
        checkOutput("reps3 valid count", nValid, 12);
        checkOutput("reps3 done count", nDone, 1);
        checkOutput("reps3 done cycle", doneCyc, 13);

        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(2, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort outputs", {28'd0, x, valid, busy, done}, 32'd0);
        abort = 1'b0;
        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(6, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        checkOutput("restart after abort bits", bits, 32'b0110);
        checkOutput("restart after abort done cycle", doneCyc, 5);

        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(5, 1'b1, 4'b1111, bits, nValid, nDone, doneCyc);
        start = 1'b0;
        runCapture(4, 1'b0, 4'b1111, bits, nValid, nDone, doneCyc);
        checkOutput("busy restart no second tx", nValid + nDone, 0);

        applyStimulus(4'b1011, 3'd0, 4'd2);
        runCapture(3, 1'b0, 4'b1011, bits, nValid, nDone, doneCyc);
        checkOutput("len0 valid count", nValid, 0);
        checkOutput("len0 done cycle", doneCyc, 1);

        applyStimulus(4'b1010, 3'd7, 4'd1);
        runCapture(6, 1'b0, 4'b1010, bits, nValid, nDone, doneCyc);
        checkOutput("len7 clamped valid count", nValid, 4);
        checkOutput("len7 clamped bits", bits, 32'b1010);

        applyStimulus(4'b1101, 3'd3, 4'd1);
        runCapture(5, 1'b0, 4'b1101, bits, nValid, nDone, doneCyc);
        checkOutput("len3 bits", bits, 32'b101);

        applyStimulus(DETECT_PATTERN, 3'd4, 4'd2);
        runCapture(2, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async reset outputs", {28'd0, x, valid, busy, done}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(6, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        checkOutput("start after reset done cycle", doneCyc, 5);
        checkOutput("start after reset bits", bits, 32'b0110);

`ifdef SEQ_GENERATOR_LOOP_EN
        loop = 1'b1;
        applyStimulus(DETECT_PATTERN, 3'd4, 4'd1);
        runCapture(10, 1'b0, DETECT_PATTERN, bits, nValid, nDone, doneCyc);
        checkOutput("loop bits", bits, 32'b0110011001);
        checkOutput("loop done count", nDone, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        loop = 1'b0;
        checkOutput("loop abort outputs", {28'd0, x, valid, busy, done}, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 24) == 0);
            pattern = W'($urandom);
            len     = LW'($urandom_range(0, 7));
            reps    = ($urandom_range(0, 9) == 0) ? R'($urandom) : R'($urandom_range(0, 3));
`ifdef SEQ_GENERATOR_LOOP_EN
            loop    = ($urandom_range(0, 3) == 0);
`endif
            if (i % 400 == 399) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        loop  = 1'b0;
        repeat (70) @(negedge clk);
        cmpEn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
